// File: rtl/bus_region_ctl.sv
// Bus-master controller: decodes the master address into one of NCS chip-select regions and
// sequences the access through fixed wait states or a slave acknowledge, with error reporting.
module bus_region_ctl #(
    parameter int                        ADDR_WIDTH   = 32,
    parameter int                        NCS          = 8,
    parameter logic [NCS*ADDR_WIDTH-1:0] REGION_BASE  = {32'hFFFF_C000, 32'h0000_0000, 32'h0080_0000,
                                                         32'h1, 32'h1, 32'h1, 32'h1, 32'h1},
    parameter logic [NCS*ADDR_WIDTH-1:0] REGION_LAST  = {32'hFFFF_FFFF, 32'h0000_3FFF, 32'h0080_07FF,
                                                         32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
    parameter logic [NCS*4-1:0]          REGION_WAIT  = {8{4'd2}},
    parameter logic [NCS-1:0]            REGION_ACKEN = '0,
    parameter int                        TIMEOUT      = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   bm_address,
    input  logic                    bm_read,
    input  logic                    bm_write,
    input  logic                    slave_ack,
    output logic                    bm_wait,
    output logic                    bm_error,
    output logic                    start,
    output logic [NCS-1:0]          chipselect,
    output logic [$clog2(NCS)-1:0]  cs_index
);

    localparam int IDX_W = $clog2(NCS);
    localparam int TO_W  = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              acken_q, acken_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic [NCS-1:0]    chipselect_q, chipselect_d;
    logic [IDX_W-1:0]  cs_index_q, cs_index_d;
    logic              start_q, start_d;
    logic              bm_error_q, bm_error_d;

    logic              req;
    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic [3:0]        dec_wait;
    logic              dec_acken;
    logic [TO_W-1:0]   tcnt_inc;
    logic              timeout_hit;
    logic              done_now;
    logic              active_d;

    assign req = bm_read | bm_write;

    // Descending scan so the lowest matching region is the last one written.
    always_comb begin
        dec_hit   = 1'b0;
        dec_idx   = '0;
        dec_wait  = '0;
        dec_acken = 1'b0;
        for (int i = NCS - 1; i >= 0; i--) begin
            if ((REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] <= bm_address) &&
                (bm_address <= REGION_LAST[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                dec_hit   = 1'b1;
                dec_idx   = IDX_W'(i);
                dec_wait  = REGION_WAIT[i*4 +: 4];
                dec_acken = REGION_ACKEN[i];
            end
        end
    end

    assign tcnt_inc    = tcnt_q + TO_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (tcnt_inc == TO_W'(TIMEOUT));
    assign done_now    = acken_q ? slave_ack : (wcnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        acken_d = acken_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = dec_idx;
                    wcnt_d  = dec_wait;
                    acken_d = dec_acken;
                    state_d = dec_hit ? S_START : S_ERROR;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = req ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_inc;
                    // Completion is checked first so it wins a tie with the timeout.
                    if (done_now) begin
                        state_d = S_DONE;
                    end else begin
                        if (!acken_q) wcnt_d = wcnt_q - 4'd1;
                        if (timeout_hit) state_d = S_ERROR;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        active_d     = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_DONE);
        chipselect_d = active_d ? (NCS'(1) << idx_d) : '0;
        cs_index_d   = active_d ? idx_d : '0;
        start_d      = (state_d == S_START);
        bm_error_d   = (state_d == S_ERROR);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            wcnt_q       <= '0;
            acken_q      <= 1'b0;
            tcnt_q       <= '0;
            chipselect_q <= '0;
            cs_index_q   <= '0;
            start_q      <= 1'b0;
            bm_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wcnt_q       <= wcnt_d;
            acken_q      <= acken_d;
            tcnt_q       <= tcnt_d;
            chipselect_q <= chipselect_d;
            cs_index_q   <= cs_index_d;
            start_q      <= start_d;
            bm_error_q   <= bm_error_d;
        end
    end

    assign bm_wait    = ((state_q == S_IDLE) && req) || (state_q == S_START) || (state_q == S_WAIT);
    assign bm_error   = bm_error_q;
    assign start      = start_q;
    assign chipselect = chipselect_q;
    assign cs_index   = cs_index_q;

endmodule

// File: tb/tb_bus_region_ctl.sv
// Directed bench for bus_region_ctl: a default instance and one with region 5 acknowledge-driven.
module tb_bus_region_ctl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] bm_address;
    logic        bm_read, bm_write, slave_ack;

    logic        bm_wait, bm_error, start;
    logic [7:0]  chipselect;
    logic [2:0]  cs_index;

    logic        a_wait, a_error, a_start;
    logic [7:0]  a_cs;
    logic [2:0]  a_idx;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    bus_region_ctl dut (
        .clock(clock), .reset_n(reset_n), .bm_address(bm_address),
        .bm_read(bm_read), .bm_write(bm_write), .slave_ack(slave_ack),
        .bm_wait(bm_wait), .bm_error(bm_error), .start(start),
        .chipselect(chipselect), .cs_index(cs_index)
    );

    bus_region_ctl #(.REGION_ACKEN(8'h20), .TIMEOUT(16)) dut_ack (
        .clock(clock), .reset_n(reset_n), .bm_address(bm_address),
        .bm_read(bm_read), .bm_write(bm_write), .slave_ack(slave_ack),
        .bm_wait(a_wait), .bm_error(a_error), .start(a_start),
        .chipselect(a_cs), .cs_index(a_idx)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_bus;
        bm_read = 1'b0; bm_write = 1'b0; slave_ack = 1'b0;
        tick(2);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; bm_read = 1'b1; bm_write = 1'b0; slave_ack = 1'b0;
        bm_address = 32'h0000_0100;
        tick(2);
        n_checks++; if (chipselect !== 8'h00) begin n_fails++; $display("FAIL rst_cs: got %h want 00", chipselect); end
        n_checks++; if ({start, bm_error, cs_index} !== 5'b0) begin n_fails++; $display("FAIL rst_flags: got %b want 00000", {start, bm_error, cs_index}); end
        n_checks++; if (bm_wait !== 1'b1) begin n_fails++; $display("FAIL rst_wait_req: got %b want 1", bm_wait); end
        bm_read = 1'b0;
        #1;
        n_checks++; if (bm_wait !== 1'b0) begin n_fails++; $display("FAIL rst_wait_noreq: got %b want 0", bm_wait); end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_fixed_read;
        bm_address = 32'h0000_0100; bm_read = 1'b1;
        #1;
        n_checks++; if (bm_wait !== 1'b1) begin n_fails++; $display("FAIL rd_c0_wait: got %b want 1", bm_wait); end
        tick(1);
        n_checks++; if ({start, chipselect, cs_index} !== {1'b1, 8'h40, 3'd6}) begin n_fails++; $display("FAIL rd_c1: start/cs/idx got %b/%h/%0d want 1/40/6", start, chipselect, cs_index); end
        bm_address = 32'h0080_0000;
        tick(1);
        n_checks++; if ({start, bm_wait, chipselect} !== {1'b0, 1'b1, 8'h40}) begin n_fails++; $display("FAIL rd_c2: start/wait/cs got %b/%b/%h want 0/1/40", start, bm_wait, chipselect); end
        tick(2);
        n_checks++; if (bm_wait !== 1'b1) begin n_fails++; $display("FAIL rd_c4_wait: got %b want 1", bm_wait); end
        tick(1);
        n_checks++; if ({bm_wait, chipselect} !== {1'b0, 8'h40}) begin n_fails++; $display("FAIL rd_c5_done: wait/cs got %b/%h want 0/40", bm_wait, chipselect); end
        tick(3);
        n_checks++; if ({bm_wait, start, chipselect} !== {1'b0, 1'b0, 8'h40}) begin n_fails++; $display("FAIL rd_held: wait/start/cs got %b/%b/%h want 0/0/40", bm_wait, start, chipselect); end
        bm_read = 1'b0;
        tick(1);
        n_checks++; if ({bm_wait, chipselect, cs_index} !== {1'b0, 8'h00, 3'd0}) begin n_fails++; $display("FAIL rd_release: wait/cs/idx got %b/%h/%0d want 0/00/0", bm_wait, chipselect, cs_index); end
        tick(1);
    endtask

    task automatic test_decode_error;
        bm_address = 32'h0080_07FF; bm_write = 1'b1;
        tick(1);
        n_checks++; if ({chipselect, cs_index} !== {8'h20, 3'd5}) begin n_fails++; $display("FAIL wr_cs: cs/idx got %h/%0d want 20/5", chipselect, cs_index); end
        tick(4);
        n_checks++; if ({bm_wait, bm_error} !== 2'b00) begin n_fails++; $display("FAIL wr_done: wait/err got %b%b want 00", bm_wait, bm_error); end
        bm_write = 1'b0;
        tick(1);
        bm_address = 32'h0080_0800; bm_write = 1'b1; bm_read = 1'b1;
        #1;
        n_checks++; if (bm_wait !== 1'b1) begin n_fails++; $display("FAIL derr_c0_wait: got %b want 1", bm_wait); end
        tick(1);
        n_checks++; if ({bm_error, bm_wait, start, chipselect} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin n_fails++; $display("FAIL derr_c1: err/wait/start/cs got %b/%b/%b/%h want 1/0/0/00", bm_error, bm_wait, start, chipselect); end
        tick(2);
        n_checks++; if (bm_error !== 1'b1) begin n_fails++; $display("FAIL derr_held: got %b want 1", bm_error); end
        bm_write = 1'b0; bm_read = 1'b0;
        tick(1);
        n_checks++; if (bm_error !== 1'b0) begin n_fails++; $display("FAIL derr_clear: got %b want 0", bm_error); end
        tick(1);
    endtask

    task automatic test_last_addr;
        bm_address = 32'hFFFF_FFFF; bm_read = 1'b1;
        tick(1);
        n_checks++; if ({chipselect, cs_index, bm_error} !== {8'h80, 3'd7, 1'b0}) begin n_fails++; $display("FAIL top_addr: cs/idx/err got %h/%0d/%b want 80/7/0", chipselect, cs_index, bm_error); end
        idle_bus();
    endtask

    task automatic test_timeout;
        bm_address = 32'h0080_0000; bm_read = 1'b1;
        tick(1);
        n_checks++; if ({a_start, a_cs} !== {1'b1, 8'h20}) begin n_fails++; $display("FAIL to_start: start/cs got %b/%h want 1/20", a_start, a_cs); end
        tick(16);
        n_checks++; if ({a_wait, a_error} !== 2'b10) begin n_fails++; $display("FAIL to_c17: wait/err got %b%b want 10", a_wait, a_error); end
        tick(1);
        n_checks++; if ({a_error, a_wait, a_cs} !== {1'b1, 1'b0, 8'h00}) begin n_fails++; $display("FAIL to_err: err/wait/cs got %b/%b/%h want 1/0/00", a_error, a_wait, a_cs); end
        idle_bus();
        // Acknowledge arriving on the last permitted WAIT cycle must complete the access.
        bm_read = 1'b1;
        tick(17);
        slave_ack = 1'b1;
        tick(1);
        slave_ack = 1'b0;
        n_checks++; if ({a_error, a_wait, a_cs} !== {1'b0, 1'b0, 8'h20}) begin n_fails++; $display("FAIL to_ack_tie: err/wait/cs got %b/%b/%h want 0/0/20", a_error, a_wait, a_cs); end
        idle_bus();
        bm_read = 1'b1;
        tick(3);
        n_checks++; if (a_wait !== 1'b1) begin n_fails++; $display("FAIL ack_pending: got %b want 1", a_wait); end
        slave_ack = 1'b1;
        tick(1);
        slave_ack = 1'b0;
        n_checks++; if ({a_wait, a_error} !== 2'b00) begin n_fails++; $display("FAIL ack_early: wait/err got %b%b want 00", a_wait, a_error); end
        idle_bus();
    endtask

    task automatic test_abort;
        bm_address = 32'h0000_0100; bm_read = 1'b1;
        tick(3);
        bm_read = 1'b0;
        tick(1);
        n_checks++; if ({bm_wait, start, chipselect} !== {1'b0, 1'b0, 8'h00}) begin n_fails++; $display("FAIL abort_idle: wait/start/cs got %b/%b/%h want 0/0/00", bm_wait, start, chipselect); end
        bm_read = 1'b1;
        tick(1);
        n_checks++; if ({start, chipselect} !== {1'b1, 8'h40}) begin n_fails++; $display("FAIL abort_restart: start/cs got %b/%h want 1/40", start, chipselect); end
        tick(4);
        n_checks++; if (bm_wait !== 1'b0) begin n_fails++; $display("FAIL restart_done: got %b want 0", bm_wait); end
        idle_bus();
    endtask

    task automatic test_back_to_back;
        bm_address = 32'h0000_0100; bm_read = 1'b1;
        tick(5);
        bm_address = 32'hFFFF_FFFF;
        tick(3);
        n_checks++; if ({start, bm_wait, chipselect} !== {1'b0, 1'b0, 8'h40}) begin n_fails++; $display("FAIL b2b_no_restart: start/wait/cs got %b/%b/%h want 0/0/40", start, bm_wait, chipselect); end
        bm_read = 1'b0;
        tick(1);
        bm_read = 1'b1;
        tick(1);
        n_checks++; if ({start, chipselect, cs_index} !== {1'b1, 8'h80, 3'd7}) begin n_fails++; $display("FAIL b2b_second: start/cs/idx got %b/%h/%0d want 1/80/7", start, chipselect, cs_index); end
        idle_bus();
    endtask

    task automatic test_async_reset;
        bm_address = 32'h0000_0100; bm_read = 1'b1;
        tick(3);
        reset_n = 1'b0;
        #1;
        n_checks++; if ({chipselect, cs_index, start, bm_error} !== 13'b0) begin n_fails++; $display("FAIL arst_outputs: cs/idx/start/err got %h/%0d/%b/%b want 00/0/0/0", chipselect, cs_index, start, bm_error); end
        bm_read = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        n_checks++; if (bm_wait !== 1'b0) begin n_fails++; $display("FAIL arst_idle_wait: got %b want 0", bm_wait); end
        bm_read = 1'b1;
        tick(1);
        n_checks++; if ({start, chipselect} !== {1'b1, 8'h40}) begin n_fails++; $display("FAIL arst_restart: start/cs got %b/%h want 1/40", start, chipselect); end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_fixed_read();
        test_decode_error();
        test_last_addr();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
